spi_slave_core: RTL and testbench
=================================

// Module: spi_slave_core
// PURPOSE
//  SPI target (slave), SPI mode 0 (CPOL=0, CPHA=0), MSB first. It is the far end of the
//  axi_spi_master link. SCK, CS and MOSI are oversampled into the ACLK domain. Received
//  words are presented on a valid/ready stream. Transmit words are taken from a one-entry
//  valid/ready holding buffer. Used as a loopback/peripheral model and as the target-side
//  core for system integration.
// PARAMETERS
//  DATA_WIDTH   8  bits per SPI word
//  SYNC_STAGES  2  synchronizer flops on SCK/CS/MOSI (min 2)
// PORTS
//  ACLK        in   1           system clock; must be >= 4x SCK frequency
//  ARESET      in   1           asynchronous reset, active-high
//  SCK         in   1           SPI clock from master
//  CS          in   1           chip select, active-low
//  MOSI        in   1           serial data from master
//  MISO        out  1           serial data to master
//  MISO_OE     out  1           1 = drive MISO (selected), 0 = release
//  tx_data     in   DATA_WIDTH  next word to transmit
//  tx_valid    in   1           tx_data valid
//  tx_ready    out  1           holding buffer empty
//  rx_data     out  DATA_WIDTH  last received word
//  rx_valid    out  1           rx_data valid
//  rx_ready    in   1           consumer accepts rx_data
//  rx_overrun  out  1           a word was dropped because rx_valid was pending
//  tx_underrun out  1           1-cycle pulse: word started with empty buffer
//  frame_err   out  1           1-cycle pulse: CS rose mid-word
//  busy        out  1           FSM in ACTIVE
// BEHAVIOUR
//  - Reset (async, any time): all outputs 0 except tx_ready=1. Buffers empty, FSM=IDLE,
//    bit_cnt=0. A partial word in flight is discarded.
//  - Sync: each pin passes through SYNC_STAGES flops. Edges are detected from the last
//    synced sample vs its registered copy. All actions below fire on detected edges.
//  - FSM IDLE: MISO=0, MISO_OE=0. On CS fall: go to ACTIVE, set MISO_OE=1, bit_cnt=0,
//    and start a word.
//  - Word start: if the buffer is full, tx_shift<=buffer and the buffer is emptied
//    (tx_ready rises the next cycle). If the buffer is empty, tx_shift<=0 and tx_underrun
//    pulses. MISO=tx_shift[MSB] from the start of the word.
//  - ACTIVE, SCK rise: rx_shift<={rx_shift[DATA_WIDTH-2:0],MOSI}, bit_cnt++.
//    When bit_cnt reaches DATA_WIDTH-1 the word is complete:
//      - if rx_valid=0 (or rx_ready=1 this cycle): rx_data<=word and rx_valid=1;
//      - otherwise the new word is dropped, rx_data is kept and rx_overrun=1;
//      - bit_cnt wraps to 0.
//  - ACTIVE, SCK fall: if bit_cnt!=0, shift tx_shift left and drive the next bit on MISO.
//    If bit_cnt==0 after a completed word, start a new word (back-to-back words in one CS).
//  - CS rise: return to IDLE, MISO_OE=0, MISO=0. If bit_cnt!=0, pulse frame_err and
//    discard the partial word (no rx_valid). The buffer is untouched.
//  - Latency: rx_valid asserts within SYNC_STAGES+2 ACLK cycles of the last SCK rising
//    edge at the pin.
//  - rx handshake: rx_valid&&rx_ready clears rx_valid the next cycle. rx_overrun is
//    sticky and clears on that same handshake.
//  - tx handshake: tx_ready=~buffer_full. tx_valid&&tx_ready loads the buffer.
//  - Simultaneous events:
//      - tx load in the same cycle as a word start: no bypass. The word sends from the
//        prior buffer state; the new data is held for the next word.
//      - rx_ready and word completion in the same cycle: the old word is handed off, the
//        new word is loaded, rx_valid stays 1, no overrun.
//  - SCK edges while CS is high are ignored. A CS glitch shorter than 1 ACLK cycle may be
//    missed; this is acceptable.
// TESTING
//  1. ACLK/8 SCK. Load tx 0x3C. Master sends 0xA5 in one CS -> rx_data=0xA5, rx_valid=1;
//     MISO bits 0,0,1,1,1,1,0,0.
//  2. Load 0x11, then 0x22 after tx_ready. One CS, master sends 0x01,0x02 -> two rx words
//     0x01,0x02; master receives 0x11,0x22; no underrun.
//  3. No tx load, master sends 0xFF -> MISO all 0, one tx_underrun pulse, rx_data=0xFF.
//  4. rx_ready=0, master sends 0x5A then 0xC3 -> rx_data=0x5A, rx_overrun=1. Then
//     rx_ready=1 -> rx_valid=0, rx_overrun=0.
//  5. CS high after 4 SCK edges -> one frame_err pulse, no rx_valid. Next full frame
//     0x96 -> rx_data=0x96.
//  6. ARESET=1 mid-word (bit 5) -> all outputs at reset values. After release, a full
//     frame 0x42 is received correctly.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI mode-0 target, MSB first; pins oversampled in ACLK, rx_valid within SYNC_STAGES+2 cycles of last SCK rise.
// rx stream holds one word (extra words dropped, rx_overrun sticky); tx takes one-entry buffer via tx_valid/tx_ready.
module spi_slave_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  SCK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic [CW-1:0]          r_bit_cnt;
    logic                   r_word_done;
    logic [DATA_WIDTH-2:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_tx_shift;
    logic [DATA_WIDTH-1:0]  r_tx_buf;
    logic                   r_tx_full;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_overrun;
    logic                   r_tx_underrun;
    logic                   r_frame_err;

    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_word_start;
    logic                   w_cs_end;
    logic                   w_sck_rise_act;
    logic                   w_shift_out;
    logic                   w_word_cplt;
    logic [DATA_WIDTH-1:0]  w_rx_word;

    // CS sync resets high so a deasserted bus never looks like a select on release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
    assign w_sck_fall = ~r_sck_sync[SYNC_STAGES-1] & r_sck_d;
    assign w_cs_rise  = r_cs_sync[SYNC_STAGES-1] & ~r_cs_d;
    assign w_cs_fall  = ~r_cs_sync[SYNC_STAGES-1] & r_cs_d;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_word_start = 1'b0;
        w_cs_end     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt  = ST_ACTIVE;
                    w_word_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_cs_end    = 1'b1;
                end else if (w_sck_fall && (r_bit_cnt == '0) && r_word_done) begin
                    w_word_start = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_sck_rise_act = (r_state == ST_ACTIVE) && !w_cs_rise && w_sck_rise;
    assign w_shift_out    = (r_state == ST_ACTIVE) && !w_cs_rise && w_sck_fall && (r_bit_cnt != '0);
    assign w_word_cplt    = w_sck_rise_act && (r_bit_cnt == LAST_BIT);
    assign w_rx_word      = {r_rx_shift, r_mosi_sync[SYNC_STAGES-1]};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_bit_cnt     <= '0;
            r_word_done   <= 1'b0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;

            if (w_word_start) begin
                r_bit_cnt   <= '0;
                r_word_done <= 1'b0;
                if (r_tx_full) begin
                    r_tx_shift <= r_tx_buf;
                end else begin
                    r_tx_shift    <= '0;
                    r_tx_underrun <= 1'b1;
                end
            end

            // Loads only land in an empty buffer, so a same-cycle start never sees them.
            if (w_word_start && r_tx_full) begin
                r_tx_full <= 1'b0;
            end else if (tx_valid && !r_tx_full) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end

            if (w_cs_end) begin
                r_bit_cnt   <= '0;
                r_word_done <= 1'b0;
                if (r_bit_cnt != '0) begin
                    r_frame_err <= 1'b1;
                end
            end

            if (w_sck_rise_act) begin
                r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
                if (w_word_cplt) begin
                    r_bit_cnt   <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_shift_out) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (r_rx_valid && rx_ready) begin
                r_rx_valid   <= 1'b0;
                r_rx_overrun <= 1'b0;
            end
            if (w_word_cplt) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= w_rx_word;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_overrun <= 1'b1;
                end
            end
        end
    end

    assign MISO        = (r_state == ST_ACTIVE) & r_tx_shift[DATA_WIDTH-1];
    assign MISO_OE     = (r_state == ST_ACTIVE);
    assign busy        = (r_state == ST_ACTIVE);
    assign tx_ready    = ~r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: SCK at ACLK/8, bench acts as SPI master.
module tb_spi_slave_core;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic       SCK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       MISO_OE;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int n_underrun = 0;
    int n_ferr = 0;
    logic [7:0] rxq[$];

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .SCK(SCK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (tx_underrun) n_underrun++;
        if (frame_err) n_ferr++;
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic tx_load(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge ACLK);
        tx_valid = 1'b0;
    endtask

    // Full frame of nw words; SCK is left high after the last bit until CS rises.
    task automatic spi_frame(input int nw, input logic [7:0] w0, input logic [7:0] w1,
                             output logic [7:0] m0, output logic [7:0] m1, output logic sel);
        logic [7:0] w;
        logic [7:0] m;
        m0 = 8'h00;
        m1 = 8'h00;
        CS = 1'b0;
        wait_clk(4);
        sel = MISO_OE & busy;
        for (int k = 0; k < nw; k++) begin
            w = (k == 0) ? w0 : w1;
            m = 8'h00;
            for (int b = 0; b < 8; b++) begin
                MOSI = w[7-b];
                wait_clk(4);
                m[7-b] = MISO;
                SCK = 1'b1;
                wait_clk(4);
                if (!(k == nw - 1 && b == 7)) SCK = 1'b0;
            end
            if (k == 0) m0 = m;
            else m1 = m;
        end
        CS = 1'b1;
        wait_clk(4);
        SCK  = 1'b0;
        MOSI = 1'b0;
        wait_clk(4);
    endtask

    task automatic spi_partial(input logic [7:0] w, input int nb);
        CS = 1'b0;
        wait_clk(4);
        for (int b = 0; b < nb; b++) begin
            MOSI = w[7-b];
            wait_clk(4);
            SCK = 1'b1;
            wait_clk(4);
            SCK = 1'b0;
        end
        wait_clk(4);
    endtask

    task automatic test_reset;
        wait_clk(3);
        checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else passes++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else passes++;
        checks++; if (MISO_OE !== 1'b0 || MISO !== 1'b0) $display("FAIL reset_miso: got oe=%b miso=%b want 0/0", MISO_OE, MISO); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (rx_data !== 8'h00 || rx_overrun !== 1'b0) $display("FAIL reset_rx: got data=%h ovr=%b want 00/0", rx_data, rx_overrun); else passes++;
        ARESET = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_basic;
        logic [7:0] m0, m1;
        logic sel;
        int u0;
        rx_ready = 1'b0;
        u0 = n_underrun;
        tx_load(8'h3C);
        checks++; if (tx_ready !== 1'b0) $display("FAIL basic_tx_full: got tx_ready=%b want 0", tx_ready); else passes++;
        spi_frame(1, 8'hA5, 8'h00, m0, m1, sel);
        checks++; if (sel !== 1'b1) $display("FAIL basic_selected: got oe&busy=%b want 1", sel); else passes++;
        checks++; if (m0 !== 8'h3C) $display("FAIL basic_miso: got %h want 3c", m0); else passes++;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) $display("FAIL basic_rx: got v=%b d=%h want 1/a5", rx_valid, rx_data); else passes++;
        checks++; if (n_underrun - u0 !== 0) $display("FAIL basic_underrun: got %0d want 0", n_underrun - u0); else passes++;
        checks++; if (tx_ready !== 1'b1 || MISO_OE !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle: got rdy=%b oe=%b busy=%b want 1/0/0", tx_ready, MISO_OE, busy); else passes++;
        rx_ready = 1'b1;
        wait_clk(1);
        checks++; if (rx_valid !== 1'b0) $display("FAIL basic_handshake: got rx_valid=%b want 0", rx_valid); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] m0, m1;
        logic sel;
        int u0;
        rx_ready = 1'b1;
        wait_clk(1);
        rxq.delete();
        u0 = n_underrun;
        tx_load(8'h11);
        fork
            spi_frame(2, 8'h01, 8'h02, m0, m1, sel);
            begin : loader
                int t;
                t = 0;
                while (!tx_ready && t < 200) begin
                    wait_clk(1);
                    t++;
                end
                checks++; if (tx_ready !== 1'b1) $display("FAIL b2b_tx_ready_wait: got %b want 1 within 200 cycles", tx_ready); else passes++;
                tx_load(8'h22);
            end
        join
        checks++; if (m0 !== 8'h11 || m1 !== 8'h22) $display("FAIL b2b_miso: got %h,%h want 11,22", m0, m1); else passes++;
        checks++; if (rxq.size() !== 2) $display("FAIL b2b_rx_count: got %0d want 2", rxq.size()); else passes++;
        if (rxq.size() == 2) begin
            checks++; if (rxq[0] !== 8'h01 || rxq[1] !== 8'h02) $display("FAIL b2b_rx_words: got %h,%h want 01,02", rxq[0], rxq[1]); else passes++;
        end
        checks++; if (n_underrun - u0 !== 0) $display("FAIL b2b_underrun: got %0d want 0", n_underrun - u0); else passes++;
    endtask

    task automatic test_underrun;
        logic [7:0] m0, m1;
        logic sel;
        int u0;
        rx_ready = 1'b1;
        rxq.delete();
        u0 = n_underrun;
        spi_frame(1, 8'hFF, 8'h00, m0, m1, sel);
        checks++; if (m0 !== 8'h00) $display("FAIL underrun_miso: got %h want 00", m0); else passes++;
        checks++; if (n_underrun - u0 !== 1) $display("FAIL underrun_pulses: got %0d want 1", n_underrun - u0); else passes++;
        checks++; if (rxq.size() !== 1 || (rxq.size() == 1 && rxq[0] !== 8'hFF)) $display("FAIL underrun_rx: got n=%0d want one word ff", rxq.size()); else passes++;
    endtask

    task automatic test_overrun;
        logic [7:0] m0, m1;
        logic sel;
        rx_ready = 1'b0;
        spi_frame(2, 8'h5A, 8'hC3, m0, m1, sel);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) $display("FAIL overrun_data: got v=%b d=%h want 1/5a", rx_valid, rx_data); else passes++;
        checks++; if (rx_overrun !== 1'b1) $display("FAIL overrun_flag: got %b want 1", rx_overrun); else passes++;
        rx_ready = 1'b1;
        wait_clk(1);
        checks++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) $display("FAIL overrun_clear: got v=%b ovr=%b want 0/0", rx_valid, rx_overrun); else passes++;
        rx_ready = 1'b0;
    endtask

    task automatic test_frame_err;
        logic [7:0] m0, m1;
        logic sel;
        int f0;
        rx_ready = 1'b0;
        f0 = n_ferr;
        spi_partial(8'hF0, 4);
        CS = 1'b1;
        wait_clk(6);
        checks++; if (n_ferr - f0 !== 1) $display("FAIL ferr_pulses: got %0d want 1", n_ferr - f0); else passes++;
        checks++; if (rx_valid !== 1'b0 || busy !== 1'b0) $display("FAIL ferr_no_rx: got v=%b busy=%b want 0/0", rx_valid, busy); else passes++;
        spi_frame(1, 8'h96, 8'h00, m0, m1, sel);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h96) $display("FAIL ferr_next_frame: got v=%b d=%h want 1/96", rx_valid, rx_data); else passes++;
        checks++; if (n_ferr - f0 !== 1) $display("FAIL ferr_clean_frame: got %0d pulses want 1", n_ferr - f0); else passes++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] m0, m1;
        logic sel;
        rx_ready = 1'b0;
        tx_load(8'h77);
        spi_partial(8'h42, 5);
        ARESET = 1'b1;
        #1;
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) $display("FAIL rstmid_rx: got v=%b d=%h want 0/00", rx_valid, rx_data); else passes++;
        checks++; if (MISO_OE !== 1'b0 || MISO !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_pins: got oe=%b miso=%b busy=%b want 0/0/0", MISO_OE, MISO, busy); else passes++;
        checks++; if (tx_ready !== 1'b1 || rx_overrun !== 1'b0) $display("FAIL rstmid_flags: got rdy=%b ovr=%b want 1/0", tx_ready, rx_overrun); else passes++;
        wait_clk(2);
        CS   = 1'b1;
        SCK  = 1'b0;
        MOSI = 1'b0;
        wait_clk(2);
        ARESET = 1'b0;
        wait_clk(4);
        spi_frame(1, 8'h42, 8'h00, m0, m1, sel);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h42) $display("FAIL rstmid_after: got v=%b d=%h want 1/42", rx_valid, rx_data); else passes++;
        checks++; if (m0 !== 8'h00) $display("FAIL rstmid_buffer_cleared: got miso %h want 00", m0); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
